// File: rtl/async_axis_fifo_wr_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | async_axis_fifo_wr_addr_gen: write-side pointer, RAM write port and      |
// | flow control of the async AXIS FIFO. Optional almost_full output is     |
// | enabled by ASYNC_AXIS_FIFO_WR_ALMOST_FULL_EN.            Revision: 1.0   |
// +--------------------------------------------------------------------------+
module async_axis_fifo_wr_addr_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
`ifdef ASYNC_AXIS_FIFO_WR_ALMOST_FULL_EN
   ,
   parameter int ALMOST_FULL_THRESH = (2**ADDR_WIDTH) - 2
`endif
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic [ADDR_WIDTH:0]   wr_count,
   input  logic [ADDR_WIDTH:0]   rd_count,
   output logic [ADDR_WIDTH:0]   wr_level
`ifdef ASYNC_AXIS_FIFO_WR_ALMOST_FULL_EN
   ,
   output logic                  almost_full
`endif
);

   localparam logic [ADDR_WIDTH:0] c_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] c_PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0]   r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_wr_ptr_d;
   logic [ADDR_WIDTH:0]   r_wr_count;
   logic [ADDR_WIDTH:0]   r_wr_level;
   logic                  r_tready;
   logic                  r_mem_wr_en;
   logic [ADDR_WIDTH-1:0] r_mem_wr_addr;
   logic [DATA_WIDTH-1:0] r_mem_wr_data;

   logic                  w_hs;
   logic [ADDR_WIDTH:0]   w_wr_ptr_next;
   logic [ADDR_WIDTH:0]   w_lvl_next;

   assign w_hs          = s_axis_tvalid & r_tready;
   assign w_wr_ptr_next = w_hs ? (r_wr_ptr + c_PTR_ONE) : r_wr_ptr;
   // Extra MSB keeps full (diff == DEPTH) distinct from empty across the wrap.
   assign w_lvl_next    = w_wr_ptr_next - rd_count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_next;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_mem_wr_en   <= 1'b0;
         r_mem_wr_addr <= '0;
         r_mem_wr_data <= '0;
      end else begin
         r_mem_wr_en <= w_hs;
         if (w_hs) begin
            r_mem_wr_addr <= r_wr_ptr[ADDR_WIDTH-1:0];
            r_mem_wr_data <= s_axis_tdata;
         end
      end
   end

   // Published count trails the pointer by one extra stage so the RAM write lands first.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr_d <= '0;
         r_wr_count <= '0;
      end else begin
         r_wr_ptr_d <= r_wr_ptr;
         r_wr_count <= r_wr_ptr_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_tready   <= 1'b0;
         r_wr_level <= '0;
      end else begin
         r_tready   <= (w_lvl_next != c_DEPTH);
         r_wr_level <= w_lvl_next;
      end
   end

`ifdef ASYNC_AXIS_FIFO_WR_ALMOST_FULL_EN
   localparam logic [ADDR_WIDTH:0] c_AF_THRESH = ALMOST_FULL_THRESH[ADDR_WIDTH:0];

   logic r_almost_full;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_almost_full <= 1'b0;
      end else begin
         r_almost_full <= (w_lvl_next >= c_AF_THRESH);
      end
   end

   assign almost_full = r_almost_full;
`endif

   assign s_axis_tready = r_tready;
   assign mem_wr_en     = r_mem_wr_en;
   assign mem_wr_addr   = r_mem_wr_addr;
   assign mem_wr_data   = r_mem_wr_data;
   assign wr_count      = r_wr_count;
   assign wr_level      = r_wr_level;

endmodule
`default_nettype wire
